apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 4, number of requesters; NUM_SLV, 6, number of APB slaves; ADDR_W, 12, address width; DATA_W, 32, data width; TIMEOUT, 255, maximum ACCESS cycles before abort.
REQ-002 Ports SHALL be, with clock and reset first:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester transfer request, level
- req_wr  in  NUM_REQ  1 = write, 0 = read, per requester
- req_addr  in  NUM_REQ*ADDR_W  packed addresses
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- resp_done  out  NUM_REQ  one-hot completion pulse
- resp_err  out  1  error flag, valid with resp_done
- resp_rdata  out  DATA_W  read data, valid with resp_done
- psel  out  NUM_SLV  one-hot slave select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  NUM_SLV*DATA_W  packed per-slave read data
- pready  in  NUM_SLV  per-slave ready
- pslverr  in  NUM_SLV  per-slave error

Function
REQ-003 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-004 In IDLE, when any eligible req bit is high, the block SHALL grant one requester round-robin, starting from the index after the last grant, and go to SETUP.
REQ-005 On grant, the block SHALL register the winner's wr, addr and wdata; these SHALL drive pwrite, paddr and pwdata unchanged until the transfer completes.
REQ-006 The slave index SHALL be paddr[ADDR_W-1:ADDR_W-3].
REQ-007 For slave index < NUM_SLV, SETUP SHALL assert psel[index] with penable=0 for exactly one cycle, then go to ACCESS with penable=1.
REQ-008 For slave index >= NUM_SLV (decode miss), SETUP SHALL assert no psel, return to IDLE, and complete with resp_err=1 and resp_rdata=0.
REQ-009 In ACCESS, the block SHALL sample pready, pslverr and prdata of the selected slave only.
REQ-010 When the selected pready=1 in ACCESS, the block SHALL deassert psel and penable on the next edge and go to IDLE.
REQ-011 In that same IDLE cycle, the block SHALL pulse resp_done[winner] for one cycle, with resp_err equal to the sampled pslverr.
REQ-012 With that pulse, resp_rdata SHALL equal the sampled prdata for reads and 0 for writes.
REQ-013 A 8-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
REQ-014 When the wait counter reaches TIMEOUT, the transfer SHALL abort to IDLE with resp_done and resp_err=1.
REQ-015 A requester SHALL hold req until its resp_done.
REQ-016 A requester whose resp_done is high in a cycle SHALL be ineligible for arbitration in that cycle.
REQ-017 Deassertion of req mid-transfer SHALL NOT abort the transfer; resp_done SHALL still pulse.
REQ-018 Minimum transfer latency SHALL be 3 cycles from grant to resp_done (zero-wait slave); back-to-back transfers SHALL issue a new SETUP every 3 cycles.
REQ-019 At most one psel bit SHALL be high at any time; penable SHALL be high only while psel is non-zero.

Reset
REQ-020 While rst=0, the state SHALL be IDLE, and psel, penable, pwrite, paddr, pwdata, resp_done, resp_err, resp_rdata and the wait counter SHALL be 0.
REQ-021 While rst=0, the round-robin pointer SHALL reset so that requester 0 has highest priority.
REQ-022 A reset asserted mid-transfer SHALL drop psel and penable asynchronously and produce no resp_done.

Structure
REQ-023 A shared package apb_pkg SHALL hold the FSM state enum, ADDR_W, DATA_W, NUM_SLV and the slave-index field position.
REQ-024 The round-robin arbiter SHALL be a separate sub-module rr_arbiter, parameterised by NUM_REQ, with inputs req, mask and advance, and output a one-hot grant.

Verification
REQ-025 Single write: req[0]=1, req_addr[0]=0x204, wdata=0xDEADBEEF, slave 1 pready=1. Required: psel=6'b000010 for 2 cycles, penable only in the 2nd, resp_done[0] 3 cycles after grant, resp_err=0.
REQ-026 Fairness: all four req held high, zero-wait slaves, each requester dropping req after its done and re-raising it the next cycle. Required: grant order 0,1,2,3,0, with one grant every 3 cycles.
REQ-027 Wait states and read: read to 0x600 (slave 3) with pready low for 5 ACCESS cycles and prdata=0x12345678. Required: resp_rdata=0x12345678, resp_err=0, PWRITE/PADDR stable throughout.
REQ-028 Decode miss and timeout: address 0xE00 yields no psel and resp_err=1; slave with pready stuck at 0 yields resp_err=1 after 255 ACCESS cycles.
REQ-029 Reset mid-ACCESS: assert rst=0 during a pending transfer. Required: psel=0 and penable=0 immediately, no resp_done, next grant goes to requester 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and bus geometry for the APB arbiter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int NUM_SLV     = 6;
  localparam int SLV_IDX_W   = 3;
  localparam int SLV_IDX_LSB = ADDR_W - SLV_IDX_W;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at the index after the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   last_q;
  logic [PTR_W-1:0]   win;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  int unsigned        idx;

  always_comb begin
    elig  = req & ~mask;
    grant = '0;
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last_q) + i) % 32'(NUM_REQ);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && elig[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          win      = PTR_W'(j);
        end
      end
    end
  end

  // Reset pointer to the last index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= PTR_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      last_q <= win;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Multi-requester APB master: round-robin arbitration, address decode to
// one-hot slave select, wait-state timeout, per-requester completion pulse.
module apb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_SLV = apb_pkg::NUM_SLV,
  parameter int ADDR_W  = apb_pkg::ADDR_W,
  parameter int DATA_W  = apb_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_done,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  import apb_pkg::*;

  apb_state_e             state_q;
  apb_state_e             state_d;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     owner_q;
  logic [7:0]             wcnt_q;
  logic                   arb_go;
  logic                   win_wr;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_wdata;
  logic [SLV_IDX_W-1:0]   slv_idx;
  logic                   hit;
  logic                   sel_ready;
  logic                   sel_err;
  logic [DATA_W-1:0]      sel_rdata;
  logic                   timeout_hit;
  logic                   done_now;

  assign arb_go = (state_q == IDLE);

  // A requester being acknowledged this cycle sits out arbitration.
  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .mask   (resp_done),
    .advance(arb_go),
    .grant  (grant)
  );

  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_wr    = req_wr[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    slv_idx   = paddr[ADDR_W-1 -: SLV_IDX_W];
    hit       = (32'(slv_idx) < 32'(NUM_SLV));
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned s = 0; s < NUM_SLV; s++) begin
      if (32'(slv_idx) == s) begin
        sel_ready = pready[s];
        sel_err   = pslverr[s];
        sel_rdata = prdata[s*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout_hit = (state_q == ACCESS) && !sel_ready && (wcnt_q == 8'(TIMEOUT - 1));
  assign done_now    = ((state_q == SETUP) && !hit) ||
                       ((state_q == ACCESS) && (sel_ready || timeout_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|grant) state_d = SETUP;
      SETUP:   state_d = hit ? ACCESS : IDLE;
      ACCESS:  if (sel_ready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register so reset drops them at once.
  always_comb begin
    psel = '0;
    for (int unsigned s = 0; s < NUM_SLV; s++) begin
      psel[s] = (state_q != IDLE) && (32'(slv_idx) == s);
    end
    penable = (state_q == ACCESS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= '0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      wcnt_q     <= '0;
      resp_done  <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if ((state_q == IDLE) && (|grant)) begin
        owner_q <= grant;
        pwrite  <= win_wr;
        paddr   <= win_addr;
        pwdata  <= win_wdata;
      end

      if (state_q == SETUP) begin
        wcnt_q <= '0;
      end else if ((state_q == ACCESS) && !sel_ready) begin
        wcnt_q <= wcnt_q + 8'd1;
      end

      resp_done  <= done_now ? owner_q : '0;
      resp_err   <= done_now && (!hit || !sel_ready || sel_err);
      resp_rdata <= (done_now && (state_q == ACCESS) && sel_ready && !pwrite) ? sel_rdata : '0;
    end
  end

  psel_onehot_a: assert property (@(posedge clk) disable iff (!rst) $onehot0(psel));
  penable_sel_a: assert property (@(posedge clk) disable iff (!rst) penable |-> (psel != '0));

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter.
module tb_apb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NUM_SLV = 6;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        resp_done;
  logic                      resp_err;
  logic [DATA_W-1:0]         resp_rdata;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  apb_arbiter #(
    .NUM_REQ(NUM_REQ),
    .NUM_SLV(NUM_SLV),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_done (resp_done),
    .resp_err  (resp_err),
    .resp_rdata(resp_rdata),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 7'b0) begin
      n_fail++; $display("FAIL reset_bus: psel/penable=%b required 0", {psel, penable});
    end
    n_tests++;
    if ({pwrite, paddr, pwdata} !== '0) begin
      n_fail++; $display("FAIL reset_addr: pwrite=%b paddr=%h pwdata=%h required 0", pwrite, paddr, pwdata);
    end
    n_tests++;
    if ({resp_done, resp_err, resp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_resp: done=%b err=%b rdata=%h required 0", resp_done, resp_err, resp_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int order[5]     = '{-1, -1, -1, -1, -1};
    int when[5]      = '{0, 0, 0, 0, 0};
    int nd           = 0;
    int who          = 0;
    logic [NUM_REQ-1:0] reraise = '0;
    req_wr = '0;
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 12'(i * 12'h200);
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 40 && nd < 5; k++) begin
      @(negedge clk);
      req     = req | reraise;
      reraise = '0;
      if (resp_done !== '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (resp_done[i]) who = i;
        order[nd] = who;
        when[nd]  = cyc;
        n_tests++;
        if (resp_rdata !== (32'hA5000000 | 32'(who))) begin
          n_fail++; $display("FAIL fair_rdata[%0d]: got %h required %h", nd, resp_rdata, 32'hA5000000 | 32'(who));
        end
        nd++;
        if (nd == 5) begin
          req = '0;
        end else begin
          reraise = resp_done;
          req     = req & ~resp_done;
        end
      end
    end
    n_tests++;
    if (nd != 5) begin
      n_fail++; $display("FAIL fair_count: got %0d completions required 5", nd);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (order[i] != exp_order[i]) begin
        n_fail++; $display("FAIL fair_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      n_tests++;
      if (when[i] - when[i-1] != 3) begin
        n_fail++; $display("FAIL fair_spacing[%0d]: got %0d cycles required 3", i, when[i] - when[i-1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req_addr[0 +: ADDR_W]  = 12'h204;
    req_wdata[0 +: DATA_W] = 32'hDEADBEEF;
    req_wr[0] = 1'b1;
    req[0]    = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 7'b0000100) begin
      n_fail++; $display("FAIL wr_setup: psel/penable=%b required 0000100", {psel, penable});
    end
    n_tests++;
    if ({pwrite, paddr, pwdata} !== {1'b1, 12'h204, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_fields: pwrite=%b paddr=%h pwdata=%h required 1 204 deadbeef", pwrite, paddr, pwdata);
    end
    @(negedge clk);
    n_tests++;
    if ({psel, penable, resp_done} !== {7'b0000101, 4'b0000}) begin
      n_fail++; $display("FAIL wr_access: psel/penable/done=%b required 00001010000", {psel, penable, resp_done});
    end
    @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 7'b0) begin
      n_fail++; $display("FAIL wr_release: psel/penable=%b required 0", {psel, penable});
    end
    n_tests++;
    if ({resp_done, resp_err, resp_rdata} !== {4'b0001, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL wr_done: done=%b err=%b rdata=%h required 0001 0 0", resp_done, resp_err, resp_rdata);
    end
    req[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (resp_done !== 4'b0000) begin
      n_fail++; $display("FAIL wr_pulse: done=%b required 0000", resp_done);
    end
  endtask

  task automatic test_req_drop();
    @(negedge clk);
    req_addr[1*ADDR_W +: ADDR_W] = 12'h200;
    req_wr[1] = 1'b0;
    req[1]    = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({resp_done, resp_rdata} !== {4'b0010, 32'hA5000001}) begin
      n_fail++; $display("FAIL drop_done: done=%b rdata=%h required 0010 a5000001", resp_done, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_read();
    logic stable = 1'b1;
    @(negedge clk);
    prdata[3*DATA_W +: DATA_W]   = 32'h12345678;
    pready[3]                    = 1'b0;
    req_addr[2*ADDR_W +: ADDR_W] = 12'h600;
    req_wr[2] = 1'b0;
    req[2]    = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 7'b0010000) begin
      n_fail++; $display("FAIL wait_setup: psel/penable=%b required 0010000", {psel, penable});
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!(penable === 1'b1 && psel === 6'b001000 && pwrite === 1'b0 &&
            paddr === 12'h600 && resp_done === 4'b0000)) stable = 1'b0;
      if (k == 5) pready[3] = 1'b1;
    end
    n_tests++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL wait_stable: bus stable=%b required 1 (last psel=%b paddr=%h)", stable, psel, paddr);
    end
    @(negedge clk);
    n_tests++;
    if ({resp_done, resp_err, resp_rdata} !== {4'b0100, 1'b0, 32'h12345678}) begin
      n_fail++; $display("FAIL wait_done: done=%b err=%b rdata=%h required 0100 0 12345678", resp_done, resp_err, resp_rdata);
    end
    req[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode_miss();
    @(negedge clk);
    req_addr[1*ADDR_W +: ADDR_W] = 12'hE00;
    req_wr[1] = 1'b1;
    req[1]    = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 7'b0) begin
      n_fail++; $display("FAIL miss_nosel: psel/penable=%b required 0", {psel, penable});
    end
    @(negedge clk);
    n_tests++;
    if ({resp_done, resp_err, resp_rdata} !== {4'b0010, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL miss_done: done=%b err=%b rdata=%h required 0010 1 0", resp_done, resp_err, resp_rdata);
    end
    req[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slverr();
    @(negedge clk);
    pslverr[0] = 1'b1;
    req_addr[3*ADDR_W +: ADDR_W] = 12'h010;
    req_wr[3] = 1'b1;
    req[3]    = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({resp_done, resp_err} !== {4'b1000, 1'b1}) begin
      n_fail++; $display("FAIL slverr_done: done=%b err=%b required 1000 1", resp_done, resp_err);
    end
    req[3]     = 1'b0;
    pslverr[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int   cnt = 0;
    logic got = 1'b0;
    @(negedge clk);
    pready[4] = 1'b0;
    req_addr[3*ADDR_W +: ADDR_W] = 12'h800;
    req_wr[3] = 1'b0;
    req[3]    = 1'b1;
    @(negedge clk);
    n_tests++;
    if (psel !== 6'b010000) begin
      n_fail++; $display("FAIL to_setup: psel=%b required 010000", psel);
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (resp_done !== 4'b0000) begin
        got = 1'b1;
        break;
      end
      if (penable === 1'b1) cnt++;
    end
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL to_bound: completion seen=%b required 1", got);
    end
    n_tests++;
    if (cnt != 255) begin
      n_fail++; $display("FAIL to_cycles: got %0d ACCESS cycles required 255", cnt);
    end
    n_tests++;
    if ({resp_done, resp_err, resp_rdata} !== {4'b1000, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL to_done: done=%b err=%b rdata=%h required 1000 1 0", resp_done, resp_err, resp_rdata);
    end
    req[3]    = 1'b0;
    pready[4] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_wr = '0;
    req_addr[0*ADDR_W +: ADDR_W] = 12'h204;
    req_addr[1*ADDR_W +: ADDR_W] = 12'hA00;
    req_addr[2*ADDR_W +: ADDR_W] = 12'h400;
    req_addr[3*ADDR_W +: ADDR_W] = 12'h600;
    pready[5] = 1'b0;
    req       = 4'b0010;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({psel, penable} !== 7'b1000001) begin
      n_fail++; $display("FAIL rst_pending: psel/penable=%b required 1000001", {psel, penable});
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({psel, penable} !== 7'b0) begin
      n_fail++; $display("FAIL rst_async: psel/penable=%b required 0", {psel, penable});
    end
    req       = 4'b1111;
    pready[5] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (resp_done !== 4'b0000) begin
      n_fail++; $display("FAIL rst_nodone: done=%b required 0000", resp_done);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({psel, resp_done} !== {6'b000010, 4'b0000}) begin
      n_fail++; $display("FAIL rst_regrant: psel/done=%b required 0000100000", {psel, resp_done});
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (resp_done !== 4'b0001) begin
      n_fail++; $display("FAIL rst_first_done: done=%b required 0001", resp_done);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    req       = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = '1;
    pslverr   = '0;
    for (int s = 0; s < NUM_SLV; s++) prdata[s*DATA_W +: DATA_W] = 32'hA5000000 | 32'(s);

    test_reset();
    test_fairness();
    test_single_write();
    test_req_drop();
    test_wait_read();
    test_decode_miss();
    test_slverr();
    test_timeout();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
